order_lanes: RTL and testbench

// Multi-lane, parametrised successor of the single-lane ordered-rule counter block.

---
 rtl/order_pkg.sv | 19 +
 rtl/order_lane.sv | 78 +++++++
 rtl/order_lanes.sv | 76 +++++++
 tb/tb_order_lanes.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// rtl/order_pkg.sv - shared constants and lane-state layout for the ordered-rule lane array
package order_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 4;
    localparam int DEF_CNTW  = 16;
    localparam int LANEW     = $clog2(DEF_LANES);

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] offset;
        logic [DEF_WIDTH-1:0] out_a;
        logic [DEF_WIDTH-1:0] out_b;
        logic [DEF_CNTW-1:0]  remaining;
        logic                 running;
        logic                 done;
    } lane_state_t;

endpackage

// File: rtl/order_lane.sv
// rtl/order_lane.sv - one lane: seed/step registers running the A/B/C update rules
module order_lane #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [WIDTH-1:0] va,
    input  logic [CNTW-1:0]  count,
    input  logic             rel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             running,
    output logic             done
);

    logic [WIDTH-1:0] a_q, a_d, offset_q, offset_d;
    logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [CNTW-1:0]  remaining_q, remaining_d;
    logic             running_q, running_d, done_q, done_d;
    logic [WIDTH-1:0] sum;

    always_comb begin
        sum         = a_q + offset_q;
        a_d         = a_q;
        offset_d    = offset_q + WIDTH'(1);
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        remaining_d = remaining_q;
        running_d   = running_q;
        done_d      = done_q & ~rel;
        if (start) begin
            a_d         = va;
            offset_d    = WIDTH'(1);
            running_d   = 1'b1;
            remaining_d = (count == '0) ? CNTW'(1) : count;
        end else if (running_q) begin
            out_a_d     = sum;
            out_b_d     = sum;
            a_d         = a_q + WIDTH'(1);
            remaining_d = remaining_q - CNTW'(1);
            if (remaining_q == CNTW'(1)) begin
                running_d = 1'b0;
                done_d    = 1'b1;
            end
        end else if (!done_q) begin
            out_b_d = sum;
            a_d     = WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            a_q         <= '0;
            offset_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            remaining_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            offset_q    <= offset_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign out_a   = out_a_q;
    assign out_b   = out_b_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: rtl/order_lanes.sv
// rtl/order_lanes.sv - lane array with request demux and round-robin completion return
module order_lanes
    import order_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     request_say_ena,
    input  logic [WIDTH-1:0]         request_say_va,
    input  logic [$clog2(LANES)-1:0] request_say_lane,
    input  logic [CNTW-1:0]          request_say_count,
    output logic                     request_say_rdy,
    output logic                     indication_result_ena,
    output logic [$clog2(LANES)-1:0] indication_result_lane,
    output logic [WIDTH-1:0]         indication_result_outa,
    output logic [WIDTH-1:0]         indication_result_outb,
    input  logic                     indication_result_rdy
);

    localparam int LW = $clog2(LANES);

    logic [LANES-1:0] running, done, start, rel;
    logic [WIDTH-1:0] out_a_v [LANES];
    logic [WIDTH-1:0] out_b_v [LANES];
    logic [LW-1:0]    ptr_q, ptr_d, sel, idx;
    logic             say_acc, ind_acc;

    assign request_say_rdy = ~running[request_say_lane] & ~done[request_say_lane];
    assign say_acc         = request_say_ena & request_say_rdy;
    assign ind_acc         = indication_result_ena & indication_result_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign start[gi] = say_acc & (request_say_lane == LW'(gi));
            assign rel[gi]   = ind_acc & (sel == LW'(gi));
            order_lane #(.WIDTH(WIDTH), .CNTW(CNTW)) u_lane (
                .CLK     (CLK),
                .nRST    (nRST),
                .start   (start[gi]),
                .va      (request_say_va),
                .count   (request_say_count),
                .rel     (rel[gi]),
                .out_a   (out_a_v[gi]),
                .out_b   (out_b_v[gi]),
                .running (running[gi]),
                .done    (done[gi])
            );
        end
    endgenerate

    // Walk from farthest to nearest so the closest done lane at/after ptr wins.
    always_comb begin
        sel = ptr_q;
        idx = ptr_q;
        for (int i = LANES - 1; i >= 0; i--) begin
            idx = ptr_q + LW'(i);
            if (done[idx]) sel = idx;
        end
        ptr_d = ind_acc ? sel + LW'(1) : ptr_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign indication_result_ena  = |done;
    assign indication_result_lane = sel;
    assign indication_result_outa = out_a_v[sel];
    assign indication_result_outb = out_b_v[sel];

endmodule

// File: tb/tb_order_lanes.sv
// tb/tb_order_lanes.sv - randomized bench for order_lanes against a closed-form completion model
module tb_order_lanes;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        say_ena = 1'b0;
    logic [31:0] say_va = '0;
    logic [1:0]  say_lane = '0;
    logic [15:0] say_count = '0;
    logic        say_rdy;
    logic        ind_ena;
    logic [1:0]  ind_lane;
    logic [31:0] ind_outa, ind_outb;
    logic        ind_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    // A lane seeded with va running n steps ends with outA = outB = va + 2n - 1.
    logic        busy [4];
    logic [31:0] res  [4];
    int          fin  [4];
    int          ptr  = 0;
    int          ecnt = 0;

    always #5 CLK = ~CLK;

    order_lanes dut (
        .CLK                    (CLK),
        .nRST                   (nRST),
        .request_say_ena        (say_ena),
        .request_say_va         (say_va),
        .request_say_lane       (say_lane),
        .request_say_count      (say_count),
        .request_say_rdy        (say_rdy),
        .indication_result_ena  (ind_ena),
        .indication_result_lane (ind_lane),
        .indication_result_outa (ind_outa),
        .indication_result_outb (ind_outb),
        .indication_result_rdy  (ind_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend(input int l);
        return busy[l] && (ecnt >= fin[l]);
    endfunction

    task automatic model_clear();
        for (int l = 0; l < 4; l++) begin
            busy[l] = 1'b0;
            res[l]  = '0;
            fin[l]  = 0;
        end
        ptr = 0;
    endtask

    task automatic cyc(input logic se, input int sl, input logic [31:0] sv,
                       input logic [15:0] sc, input logic ir);
        bit exp_rdy, any, acc_s, acc_i;
        int pick, n;
        @(negedge CLK);
        say_ena   = se;
        say_lane  = 2'(sl);
        say_va    = sv;
        say_count = sc;
        ind_rdy   = ir;
        #1;
        exp_rdy = !busy[sl];
        chk("say_rdy", 64'(say_rdy), 64'(exp_rdy));
        any  = 1'b0;
        pick = 0;
        for (int i = 3; i >= 0; i--) begin
            if (pend((ptr + i) % 4)) begin
                any  = 1'b1;
                pick = (ptr + i) % 4;
            end
        end
        chk("ind_ena", 64'(ind_ena), 64'(any));
        if (any) begin
            chk("ind_lane", 64'(ind_lane), 64'(pick));
            chk("ind_outa", 64'(ind_outa), 64'(res[pick]));
            chk("ind_outb", 64'(ind_outb), 64'(res[pick]));
        end
        acc_s = se && exp_rdy;
        acc_i = any && ir;
        @(posedge CLK);
        ecnt++;
        if (acc_i) begin
            busy[pick] = 1'b0;
            ptr = (pick + 1) % 4;
        end
        if (acc_s) begin
            n = (sc == 16'd0) ? 1 : int'(sc);
            busy[sl] = 1'b1;
            res[sl]  = sv + 32'(2 * n - 1);
            fin[sl]  = ecnt + n;
        end
    endtask

    task automatic reset_checks();
        for (int l = 0; l < 4; l++) begin
            @(negedge CLK);
            say_ena  = 1'b0;
            ind_rdy  = 1'b1;
            say_lane = 2'(l);
            #1;
            chk("rst_say_rdy", 64'(say_rdy), 64'd1);
            chk("rst_ind_ena", 64'(ind_ena), 64'd0);
            chk("rst_outa", 64'(ind_outa), 64'd0);
            chk("rst_outb", 64'(ind_outb), 64'd0);
        end
    endtask

    initial begin
        model_clear();
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        reset_checks();
        @(negedge CLK);
        nRST = 1'b1;

        // single run, then busy refusal with a concurrent accept on lane 1
        cyc(1'b1, 2, 32'd10, 16'd3, 1'b1);
        repeat (5) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);
        cyc(1'b1, 2, 32'd20, 16'd6, 1'b1);
        cyc(1'b1, 2, 32'd99, 16'd2, 1'b1);
        cyc(1'b1, 1, 32'd5, 16'd2, 1'b1);
        repeat (8) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);

        // count zero, then a lane3 run leaves the pointer at 0
        cyc(1'b1, 0, 32'd7, 16'd0, 1'b1);
        repeat (3) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);
        cyc(1'b1, 3, 32'd40, 16'd1, 1'b1);
        repeat (3) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);

        // lanes 0, 1, 3 complete together under backpressure
        cyc(1'b1, 0, 32'd100, 16'd5, 1'b0);
        cyc(1'b1, 1, 32'd200, 16'd4, 1'b0);
        cyc(1'b1, 3, 32'd300, 16'd3, 1'b0);
        repeat (2) cyc(1'b0, 0, 32'd0, 16'd0, 1'b0);
        repeat (5) cyc(1'b0, 0, 32'd0, 16'd0, 1'b0);
        repeat (4) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);

        // wrap-around seed
        cyc(1'b1, 1, 32'hFFFF_FFFE, 16'd2, 1'b1);
        repeat (4) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);

        for (int k = 0; k < 1500; k++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 32'($urandom),
                16'($urandom_range(0, 6)), ($urandom_range(0, 9) < 7));
        end
        repeat (10) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);

        // reset mid-run discards the lane
        cyc(1'b1, 1, 32'd55, 16'd8, 1'b1);
        repeat (3) cyc(1'b0, 0, 32'd0, 16'd0, 1'b1);
        @(negedge CLK);
        nRST = 1'b0;
        @(posedge CLK);
        reset_checks();
        model_clear();
        @(negedge CLK);
        nRST = 1'b1;
        repeat (12) cyc(1'b0, 1, 32'd0, 16'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
